reloj_tiempo: RTL and testbench
===============================

RELOJ_TIEMPO -- requirements
Module: reloj_tiempo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk samples every register on its rising edge, and reset is sampled on that edge only.
REQ-002 Port clk SHALL be an input, 1 bit wide: the system clock.
REQ-003 Port reset SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-004 Port tick1hz SHALL be an input, 1 bit wide: a one-clk-wide enable pulse, once per second.
REQ-005 Port minreloj SHALL be an input, 1 bit wide: the set-minutes level, high for as long as the button is held (from the button mux).
REQ-006 Port horreloj SHALL be an input, 1 bit wide: the set-hours level, high for as long as the button is held (from the button mux).
REQ-007 Port hor_d SHALL be an output, 2 bits wide: hours tens, BCD 0-2.
REQ-008 Port hor_u SHALL be an output, 4 bits wide: hours units, BCD 0-9.
REQ-009 Port min_d SHALL be an output, 3 bits wide: minutes tens, BCD 0-5.
REQ-010 Port min_u SHALL be an output, 4 bits wide: minutes units, BCD 0-9.
REQ-011 Port seg_d SHALL be an output, 3 bits wide: seconds tens, BCD 0-5.
REQ-012 Port seg_u SHALL be an output, 4 bits wide: seconds units, BCD 0-9.
REQ-013 Port inc_min SHALL be an output, 1 bit wide: a registered one-clk pulse marking each applied minute-set increment.
REQ-014 Port inc_hor SHALL be an output, 1 bit wide: a registered one-clk pulse marking each applied hour-set increment.

Function
REQ-015 Each time-digit output SHALL be driven directly from a register, with no combinational path from inputs to outputs.
REQ-016 The block SHALL hold time in 24-hour format, 00:00:00 to 23:59:59, with every digit encoded in BCD.
REQ-017 On tick1hz=1 with no set increment in the same cycle, the time SHALL advance by 1 s in that cycle.
REQ-018 The tick advance SHALL ripple through all carries in the same cycle: seconds 59->00 carries into minutes, minutes 59->00 carries into hours, and 23:59:59 wraps to 00:00:00.
REQ-019 Minreloj and horreloj SHALL each feed an independent 3-state repeat FSM with states IDLE, ESPERA and REPITE.
REQ-020 In IDLE, a sampled 0->1 edge of the button level SHALL produce one increment in that cycle and move the FSM to ESPERA with its tick count cleared.
REQ-021 In ESPERA, each tick1hz while the button is held SHALL increment a 2-bit tick counter; when the counter reaches 2 the FSM SHALL move to REPITE, with no increment on that tick.
REQ-022 In REPITE, every tick1hz while the button is held SHALL produce one increment.
REQ-023 In any state, button level=0 SHALL return the FSM to IDLE on the next clk, with no increment.
REQ-024 A minute increment SHALL take minutes mod 60 (59->00), SHALL NOT carry into hours, and SHALL clear seconds to 00.
REQ-025 An hour increment SHALL take hours mod 24 (23->00), and SHALL leave minutes and seconds unchanged.
REQ-026 When a minute and an hour increment fall in the same cycle, both SHALL apply.
REQ-027 When any set increment occurs, tick1hz in that same cycle SHALL be discarded, so no seconds advance and no carry occur.
REQ-028 When minreloj and horreloj are both held, each FSM SHALL run independently.
REQ-029 inc_min and inc_hor SHALL pulse high in the clk after the cycle in which the corresponding increment is applied.
REQ-030 BCD digits SHALL never hold illegal codes (for example min_u>9 or hor=24..29) after any sequence of inputs.

Reset
REQ-031 While reset=1 at a clk edge, time SHALL go to 00:00:00, both FSMs to IDLE, tick counters to 0, inc_min/inc_hor to 0, and edge-detect history to 0.
REQ-032 Reset SHALL override tick1hz and both set inputs in the same cycle.
REQ-033 If a button is already high when reset deasserts, that SHALL count as a 0->1 edge on the first post-reset sample, giving one increment.
REQ-034 Reset asserted mid-repeat SHALL abort the repeat with no further increments until a new edge occurs.

Verification
REQ-035 Reset, then 86400 tick1hz pulses spaced 4 clk apart -> the time reads 00:00:00 again, passing 23:59:59, with outputs equal to 00:00:00 after tick 86400.
REQ-036 Time at 12:59:59, hold minreloj for 1 clk -> 12:00:00 with the hour unchanged, and inc_min pulses exactly once.
REQ-037 Time at 23:10:20, hold horreloj and apply 5 ticks -> edge gives 00:10:20, ticks 1-2 hold it, ticks 3-5 give 03:10:20, and inc_hor pulses 4 times in total.
REQ-038 Time at 05:30:59, minreloj edge and tick1hz in the same cycle -> 05:31:00, with the tick discarded.
REQ-039 Minreloj and horreloj rising in the same cycle at 23:59:10 -> 00:00:00.
REQ-040 Assert reset for 1 clk during REPITE with the button still held -> 00:00:00, then exactly one increment on the first post-reset cycle, giving 00:01:00.

Source files
------------

// File: rtl/reloj_tiempo.sv
// 24-hour BCD clock with set-minutes / set-hours buttons that auto-repeat when held.
// Every digit and pulse output is a register; only the increment strobes are combinational internally.

module reloj_rep (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic level,
    output logic inc,
    output logic pulse
);
    // state  | meaning
    // IDLE   | button released, waiting for a 0->1 edge
    // ESPERA | first increment done, counting two ticks before repeating
    // REPITE | one increment per tick while the button stays held
    typedef enum logic [1:0] {IDLE, ESPERA, REPITE} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       prev;

    always_comb begin
        inc = 1'b0;
        case (state)
            IDLE:    inc = level & ~prev;
            REPITE:  inc = level & tick;
            default: inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= inc;
            case (state)
                IDLE: begin
                    if (level && !prev) begin
                        state <= ESPERA;
                        cnt   <= 2'd0;
                    end
                end
                ESPERA: begin
                    if (!level) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd1) state <= REPITE;
                    end
                end
                REPITE: begin
                    if (!level) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module reloj_tiempo (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick1hz,
    input  logic       minreloj,
    input  logic       horreloj,
    output logic [1:0] hor_d,
    output logic [3:0] hor_u,
    output logic [2:0] min_d,
    output logic [3:0] min_u,
    output logic [2:0] seg_d,
    output logic [3:0] seg_u,
    output logic       inc_min,
    output logic       inc_hor
);
    logic set_min, set_hor;

    reloj_rep u_rep_min (
        .clk   (clk),
        .reset (reset),
        .tick  (tick1hz),
        .level (minreloj),
        .inc   (set_min),
        .pulse (inc_min)
    );

    reloj_rep u_rep_hor (
        .clk   (clk),
        .reset (reset),
        .tick  (tick1hz),
        .level (horreloj),
        .inc   (set_hor),
        .pulse (inc_hor)
    );

    // Terminal-count tests use >= so a corrupted digit still folds back to a legal code.
    logic seg_wrap, min_wrap, hor_wrap;
    assign seg_wrap = (seg_d >= 3'd5) && (seg_u >= 4'd9);
    assign min_wrap = (min_d >= 3'd5) && (min_u >= 4'd9);
    assign hor_wrap = (hor_d >= 2'd2) && (hor_u >= 4'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            hor_d <= 2'd0;
            hor_u <= 4'd0;
            min_d <= 3'd0;
            min_u <= 4'd0;
            seg_d <= 3'd0;
            seg_u <= 4'd0;
        end else if (set_min || set_hor) begin
            if (set_hor) begin
                if (hor_wrap) begin
                    hor_d <= 2'd0;
                    hor_u <= 4'd0;
                end else if (hor_u >= 4'd9) begin
                    hor_d <= hor_d + 2'd1;
                    hor_u <= 4'd0;
                end else begin
                    hor_u <= hor_u + 4'd1;
                end
            end
            if (set_min) begin
                seg_d <= 3'd0;
                seg_u <= 4'd0;
                if (min_wrap) begin
                    min_d <= 3'd0;
                    min_u <= 4'd0;
                end else if (min_u >= 4'd9) begin
                    min_d <= min_d + 3'd1;
                    min_u <= 4'd0;
                end else begin
                    min_u <= min_u + 4'd1;
                end
            end
        end else if (tick1hz) begin
            if (seg_u >= 4'd9) begin
                seg_u <= 4'd0;
                if (seg_wrap) begin
                    seg_d <= 3'd0;
                    if (min_u >= 4'd9) begin
                        min_u <= 4'd0;
                        if (min_wrap) begin
                            min_d <= 3'd0;
                            if (hor_wrap) begin
                                hor_d <= 2'd0;
                                hor_u <= 4'd0;
                            end else if (hor_u >= 4'd9) begin
                                hor_d <= hor_d + 2'd1;
                                hor_u <= 4'd0;
                            end else begin
                                hor_u <= hor_u + 4'd1;
                            end
                        end else begin
                            min_d <= min_d + 3'd1;
                        end
                    end else begin
                        min_u <= min_u + 4'd1;
                    end
                end else begin
                    seg_d <= seg_d + 3'd1;
                end
            end else begin
                seg_u <= seg_u + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_reloj_tiempo.sv
// Scoreboarded bench for reloj_tiempo: a seconds-of-day reference model predicts
// time and increment pulses each cycle; directed scenarios add spot checks.

module tb_reloj_tiempo;
    logic       clk = 1'b0;
    logic       reset = 1'b0, tick1hz = 1'b0, minreloj = 1'b0, horreloj = 1'b0;
    logic [1:0] hor_d;
    logic [3:0] hor_u;
    logic [2:0] min_d;
    logic [3:0] min_u;
    logic [2:0] seg_d;
    logic [3:0] seg_u;
    logic       inc_min, inc_hor;

    int checks = 0;
    int errors = 0;
    int pulses_m = 0;
    int pulses_h = 0;

    // reference model state
    int  day_s = 0;
    int  st  [2] = '{0, 0};
    int  cnt [2] = '{0, 0};
    logic prv[2] = '{1'b0, 1'b0};

    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    reloj_tiempo dut (
        .clk      (clk),
        .reset    (reset),
        .tick1hz  (tick1hz),
        .minreloj (minreloj),
        .horreloj (horreloj),
        .hor_d    (hor_d),
        .hor_u    (hor_u),
        .min_d    (min_d),
        .min_u    (min_u),
        .seg_d    (seg_d),
        .seg_u    (seg_u),
        .inc_min  (inc_min),
        .inc_hor  (inc_hor)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] bcd(input int s);
        int hh, mm, ss;
        hh = s / 3600;
        mm = (s / 60) % 60;
        ss = s % 60;
        return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [19:0] hms(input int hh, input int mm, input int ss);
        return bcd(hh * 3600 + mm * 60 + ss);
    endfunction

    function automatic logic [19:0] dut_time();
        return {hor_d, hor_u, min_d, min_u, seg_d, seg_u};
    endfunction

    task automatic model_btn(input int b, input logic lvl, input logic t, output logic inc);
        inc = 1'b0;
        if (st[b] == 0) begin
            if (lvl && !prv[b]) begin
                inc = 1'b1;
                st[b] = 1;
                cnt[b] = 0;
            end
        end else if (!lvl) begin
            st[b] = 0;
        end else if (t) begin
            if (st[b] == 2) begin
                inc = 1'b1;
            end else begin
                cnt[b] = cnt[b] + 1;
                if (cnt[b] == 2) st[b] = 2;
            end
        end
        prv[b] = lvl;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic cyc(input logic r, input logic t, input logic m, input logic h);
        logic im, ih;
        logic [21:0] e;
        int hh, mm, ss;
        reset = r; tick1hz = t; minreloj = m; horreloj = h;
        if (r) begin
            day_s = 0;
            st = '{0, 0}; cnt = '{0, 0}; prv = '{1'b0, 1'b0};
            im = 1'b0; ih = 1'b0;
        end else begin
            model_btn(0, m, t, im);
            model_btn(1, h, t, ih);
            if (im || ih) begin
                hh = day_s / 3600;
                mm = (day_s / 60) % 60;
                ss = day_s % 60;
                if (ih) hh = (hh + 1) % 24;
                if (im) begin
                    mm = (mm + 1) % 60;
                    ss = 0;
                end
                day_s = hh * 3600 + mm * 60 + ss;
            end else if (t) begin
                day_s = (day_s + 1) % 86400;
            end
        end
        exp_q.push_back({bcd(day_s), im, ih});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("cycle", {10'd0, dut_time(), inc_min, inc_hor}, {10'd0, e});
        pulses_m += int'(inc_min);
        pulses_h += int'(inc_hor);
        @(negedge clk);
    endtask

    task automatic press_h(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic press_m(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic ticks(input int n, input int gap, input logic m, input logic h);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, m, h);
            for (int j = 1; j < gap; j++) cyc(0, 0, m, h);
        end
    endtask

    task automatic set_time(input int hh, input int mm, input int ss);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        press_h(hh);
        press_m(mm);
        ticks(ss, 2, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        // reset wins over tick and both buttons
        cyc(1, 1, 1, 1);
        chk("reset_time", {12'd0, dut_time()}, 32'd0);
        chk("reset_inc", {30'd0, inc_min, inc_hor}, 32'd0);
        cyc(1, 0, 0, 0);

        // minute set at 12:59:59: no hour carry, seconds cleared
        set_time(12, 59, 59);
        chk("preset_125959", {12'd0, dut_time()}, {12'd0, hms(12, 59, 59)});
        pulses_m = 0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("min_wrap_time", {12'd0, dut_time()}, {12'd0, hms(12, 0, 0)});
        chk("min_wrap_pulses", pulses_m, 1);

        // minute edge together with a tick: tick discarded
        set_time(5, 30, 59);
        cyc(0, 1, 1, 0);
        chk("tick_discard", {12'd0, dut_time()}, {12'd0, hms(5, 31, 0)});
        cyc(0, 0, 0, 0);

        // both buttons rising together at 23:59:10
        set_time(23, 59, 10);
        cyc(0, 0, 1, 1);
        chk("both_set", {12'd0, dut_time()}, {12'd0, hms(0, 0, 0)});
        cyc(0, 0, 0, 0);

        // held hour button: edge, two waiting ticks, then repeats
        set_time(23, 10, 20);
        pulses_h = 0;
        cyc(0, 0, 0, 1);
        chk("hour_edge", {24'd0, hor_d, hor_u}, 32'd0);
        ticks(5, 4, 1'b0, 1'b1);
        cyc(0, 0, 0, 0);
        chk("hour_repeat", {24'd0, hor_d, hor_u}, 32'h03);
        chk("hour_min_kept", {25'd0, min_d, min_u}, 32'h10);
        chk("hour_pulses", pulses_h, 4);

        // independent repeat on both buttons held together
        set_time(1, 2, 3);
        cyc(0, 0, 1, 1);
        ticks(6, 3, 1'b1, 1'b1);
        cyc(0, 0, 0, 0);

        // reset mid-repeat with minute button held
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        ticks(3, 2, 1'b1, 1'b0);
        cyc(1, 0, 1, 0);
        chk("mid_reset", {12'd0, dut_time()}, 32'd0);
        cyc(0, 0, 1, 0);
        chk("post_reset_edge", {12'd0, dut_time()}, {12'd0, hms(0, 1, 0)});
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("no_extra_inc", {12'd0, dut_time()}, {12'd0, hms(0, 1, 0)});
        cyc(0, 0, 0, 0);

        // ripple across midnight with ticks spaced 4 clk
        set_time(23, 58, 0);
        ticks(240, 4, 1'b0, 1'b0);
        chk("midnight_roll", {12'd0, dut_time()}, {12'd0, hms(0, 2, 0)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
